// File: rtl/udma_uart_job_seq.sv
// udma_uart_job_seq
//   Runs one UART uDMA job at a time on behalf of the core. For each accepted
//   job it optionally writes UART_SETUP, then programs the channel SADDR, SIZE
//   and CFG(enable) registers. It then polls the channel CFG register until
//   the transfer finishes. The outcome is a one-cycle done_o or err_o pulse.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   job handshake (ready only while IDLE)
//   req_dir_i             0 = TX channel (base 4), 1 = RX channel (base 0)
//   req_addr_i/size_i     L2 buffer start address / size in bytes
//   req_setup_en_i/_i     optional UART_SETUP (address 9) write value
//   busy_o                job in progress
//   done_o / err_o        one-cycle completion / rejection-or-timeout pulses
//   cfg_*                 register bus master; request fields held while valid
module udma_uart_job_seq #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int POLL_GAP       = 8,
  parameter int MAX_POLLS      = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_dir_i,
  input  logic [L2_AWIDTH_NOAL-1:0] req_addr_i,
  input  logic [TRANS_SIZE-1:0]     req_size_i,
  input  logic                      req_setup_en_i,
  input  logic [31:0]               req_setup_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  output logic [4:0]                cfg_addr_o,
  output logic [31:0]               cfg_data_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i
);

  localparam int GCW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
  localparam int PCW = (MAX_POLLS < 2) ? 1 : $clog2(MAX_POLLS + 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(POLL_GAP - 1);
  localparam logic [PCW-1:0] POLL_LIM  = PCW'(MAX_POLLS);
  localparam logic [4:0]     SETUP_ADR = 5'd9;
  localparam logic [31:0]    CFG_EN    = 32'h10;
  localparam logic [31:0]    CFG_CLR   = 32'h40;

  typedef enum logic [3:0] {
    IDLE, SETUP, SADDR, SIZE, CFG, GAP, POLL, CLR, DONE, ERR
  } state_t;

  state_t                    state;
  logic [GCW-1:0]            gap_cnt;
  logic [PCW-1:0]            poll_cnt;
  logic [PCW-1:0]            poll_cnt_nxt;
  logic                      dir_q;
  logic [L2_AWIDTH_NOAL-1:0] addr_q;
  logic [TRANS_SIZE-1:0]     size_q;
  logic [4:0]                base_q;
  logic                      xfer_idle;
  logic                      unused_cfg_data;

  function automatic logic [4:0] chan_base(input logic dir);
    return dir ? 5'd0 : 5'd4;
  endfunction

  // Poll counter holds at all-ones rather than wrapping.
  function automatic logic [PCW-1:0] sat_inc(input logic [PCW-1:0] v);
    return (v == '1) ? v : v + PCW'(1);
  endfunction

  assign req_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign base_q       = chan_base(dir_q);
  assign poll_cnt_nxt = sat_inc(poll_cnt);
  // Channel finished when both en (bit4) and pending (bit5) have cleared.
  assign xfer_idle    = ~cfg_data_i[4] & ~cfg_data_i[5];
  assign unused_cfg_data = ^{cfg_data_i[31:6], cfg_data_i[3:0]};

  // Job parameters: plain data, captured on acceptance, no reset needed.
  always_ff @(posedge clk_i) begin
    if (req_ready_o && req_valid_i) begin
      dir_q  <= req_dir_i;
      addr_q <= req_addr_i;
      size_q <= req_size_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      cfg_valid_o <= 1'b0;
      cfg_rwn_o   <= 1'b0;
      cfg_addr_o  <= '0;
      cfg_data_o  <= '0;
      gap_cnt     <= '0;
      poll_cnt    <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            poll_cnt <= '0;
            if (req_size_i == '0) begin
              state <= ERR;
              err_o <= 1'b1;
            end else if (req_setup_en_i) begin
              state       <= SETUP;
              cfg_valid_o <= 1'b1;
              cfg_rwn_o   <= 1'b0;
              cfg_addr_o  <= SETUP_ADR;
              cfg_data_o  <= req_setup_i;
            end else begin
              // Latched copies are not visible yet, so use the request inputs.
              state       <= SADDR;
              cfg_valid_o <= 1'b1;
              cfg_rwn_o   <= 1'b0;
              cfg_addr_o  <= chan_base(req_dir_i);
              cfg_data_o  <= 32'(req_addr_i);
            end
          end
        end
        SETUP: if (cfg_ready_i) begin
          state      <= SADDR;
          cfg_addr_o <= base_q;
          cfg_data_o <= 32'(addr_q);
        end
        SADDR: if (cfg_ready_i) begin
          state      <= SIZE;
          cfg_addr_o <= base_q + 5'd1;
          cfg_data_o <= 32'(size_q);
        end
        SIZE: if (cfg_ready_i) begin
          state      <= CFG;
          cfg_addr_o <= base_q + 5'd2;
          cfg_data_o <= CFG_EN;
        end
        CFG: if (cfg_ready_i) begin
          state       <= GAP;
          cfg_valid_o <= 1'b0;
          gap_cnt     <= '0;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state       <= POLL;
            cfg_valid_o <= 1'b1;
            cfg_rwn_o   <= 1'b1;
            cfg_addr_o  <= base_q + 5'd2;
            cfg_data_o  <= '0;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        POLL: if (cfg_ready_i) begin
          poll_cnt <= poll_cnt_nxt;
          if (xfer_idle) begin
            state       <= DONE;
            cfg_valid_o <= 1'b0;
            done_o      <= 1'b1;
          end else if (MAX_POLLS != 0 && poll_cnt_nxt == POLL_LIM) begin
            // Give up: disable and clear the channel before reporting.
            state      <= CLR;
            cfg_rwn_o  <= 1'b0;
            cfg_data_o <= CFG_CLR;
          end else begin
            state       <= GAP;
            cfg_valid_o <= 1'b0;
            gap_cnt     <= '0;
          end
        end
        CLR: if (cfg_ready_i) begin
          state       <= ERR;
          cfg_valid_o <= 1'b0;
          err_o       <= 1'b1;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_uart_job_seq.sv
module tb_udma_uart_job_seq;

  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_dir, req_setup_en;
  logic [11:0] req_addr;
  logic [15:0] req_size;
  logic [31:0] req_setup;
  logic        sel;
  logic [31:0] cfg_rdata;
  logic        cfg_ready;

  logic        a_ready, a_busy, a_done, a_err, a_valid, a_rwn;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_ready, b_busy, b_done, b_err, b_valid, b_rwn;
  logic [4:0]  b_addr;
  logic [31:0] b_data;

  logic        m_ready, m_busy, m_done, m_err, m_valid, m_rwn;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_log = 0, n_reads = 0, n_stall = 0, n_done = 0, n_err = 0;
  int done_cyc = 0, err_cyc = 0;
  int rd_base = 0, busy_polls = 0;
  logic [31:0] busy_val = 32'h0;
  logic        stall_on = 1'b0;
  logic [4:0]  stall_addr = 5'd0;
  logic [31:0] stall_data = 32'h0;
  int          stall_cnt = 0;

  logic        log_rwn  [0:63];
  logic [4:0]  log_addr [0:63];
  logic [31:0] log_data [0:63];
  int          log_cyc  [0:63];

  always #5 clk = ~clk;

  udma_uart_job_seq #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .POLL_GAP(GAP), .MAX_POLLS(1024)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & ~sel), .req_ready_o(a_ready),
    .req_dir_i(req_dir), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_setup_en_i(req_setup_en), .req_setup_i(req_setup),
    .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
    .cfg_valid_o(a_valid), .cfg_rwn_o(a_rwn), .cfg_addr_o(a_addr), .cfg_data_o(a_data),
    .cfg_data_i(cfg_rdata), .cfg_ready_i(cfg_ready));

  udma_uart_job_seq #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16), .POLL_GAP(GAP), .MAX_POLLS(2)) dut_t (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & sel), .req_ready_o(b_ready),
    .req_dir_i(req_dir), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_setup_en_i(req_setup_en), .req_setup_i(req_setup),
    .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
    .cfg_valid_o(b_valid), .cfg_rwn_o(b_rwn), .cfg_addr_o(b_addr), .cfg_data_o(b_data),
    .cfg_data_i(cfg_rdata), .cfg_ready_i(cfg_ready));

  assign m_ready = sel ? b_ready : a_ready;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_err   = sel ? b_err   : a_err;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_rwn   = sel ? b_rwn   : a_rwn;
  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_data  = sel ? b_data  : a_data;

  // Slave model: stalls one chosen address for 5 cycles; poll replies busy_val
  // for the first busy_polls reads of a test, then 0 (channel idle).
  assign cfg_ready = !(stall_on && m_valid && m_addr == stall_addr && stall_cnt < 5);
  assign cfg_rdata = ((n_reads - rd_base) < busy_polls) ? busy_val : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_valid && cfg_ready && m_rwn) n_reads <= n_reads + 1;
    if (stall_on && m_valid && m_addr == stall_addr && stall_cnt < 5) stall_cnt <= stall_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid && cfg_ready && n_log < 64) begin
      log_rwn[n_log]  = m_rwn;
      log_addr[n_log] = m_addr;
      log_data[n_log] = m_data;
      log_cyc[n_log]  = cyc;
      n_log++;
    end
    if (m_valid && !cfg_ready) begin
      n_stall++;
      chk("stall_addr", {27'd0, m_addr}, {27'd0, stall_addr});
      chk("stall_data", m_data, stall_data);
    end
    if (m_done) begin n_done++; done_cyc = cyc; end
    if (m_err)  begin n_err++;  err_cyc  = cyc; end
    if (m_done || m_err) chk("done_err_excl", {31'd0, m_done & m_err}, 32'd0);
  end

  task automatic chk_log(input string tag, input int i, input logic rwn,
                         input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_rwn"},  {31'd0, log_rwn[i]}, {31'd0, rwn});
    chk({tag, "_addr"}, {27'd0, log_addr[i]}, {27'd0, a});
    if (!rwn) chk({tag, "_data"}, log_data[i], d);
  endtask

  task automatic run_job(input logic dir, input logic [11:0] addr, input logic [15:0] size,
                         input logic sen, input logic [31:0] setup, output int acc);
    @(negedge clk);
    req_valid = 1'b1; req_dir = dir; req_addr = addr; req_size = size;
    req_setup_en = sen; req_setup = setup;
    chk("req_ready", {31'd0, m_ready}, 32'd1);
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 12'hFFF; req_size = 16'hFFFF; req_setup = 32'hDEAD_BEEF;
  endtask

  task automatic wait_evt(input int nd0, input int ne0);
    int k;
    k = 0;
    while (n_done == nd0 && n_err == ne0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk("job_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {26'd0, m_ready, m_busy, m_valid, m_rwn, m_done, m_err}, {26'd0, 6'b100000});
    chk({tag, "_addr"}, {27'd0, m_addr}, 32'd0);
    chk({tag, "_data"}, m_data, 32'd0);
  endtask

  initial begin
    int acc, lb, nd, ne, ns;
    rst = 1'b1; req_valid = 1'b0; req_dir = 1'b0; req_addr = '0; req_size = '0;
    req_setup_en = 1'b0; req_setup = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    // 1: TX with UART_SETUP, first poll reports idle
    lb = n_log; nd = n_done; ne = n_err; rd_base = n_reads; busy_polls = 0;
    run_job(1'b0, 12'h100, 16'd16, 1'b1, 32'h01B4_0306, acc);
    wait_evt(nd, ne);
    chk("t1_nlog", n_log - lb, 32'd5);
    chk_log("t1_w0", lb,     1'b0, 5'd9, 32'h01B4_0306);
    chk_log("t1_w1", lb + 1, 1'b0, 5'd4, 32'h100);
    chk_log("t1_w2", lb + 2, 1'b0, 5'd5, 32'd16);
    chk_log("t1_w3", lb + 3, 1'b0, 5'd6, 32'h10);
    chk_log("t1_rd", lb + 4, 1'b1, 5'd6, 32'h0);
    chk("t1_w0_cyc", log_cyc[lb], acc + 1);
    chk("t1_w3_cyc", log_cyc[lb + 3], acc + 4);
    chk("t1_rd_cyc", log_cyc[lb + 4], acc + 4 + GAP + 1);
    chk("t1_done_cyc", done_cyc, acc + 4 + GAP + 2);
    chk("t1_ndone", n_done - nd, 32'd1);
    chk("t1_nerr", n_err - ne, 32'd0);
    chk("t1_idle", {31'd0, m_busy}, 32'd0);

    // 2: RX without setup, channel busy for three polls
    lb = n_log; nd = n_done; ne = n_err; rd_base = n_reads; busy_polls = 3; busy_val = 32'h30;
    run_job(1'b1, 12'h02A, 16'd4, 1'b0, 32'h0, acc);
    wait_evt(nd, ne);
    chk("t2_nlog", n_log - lb, 32'd7);
    chk_log("t2_w0", lb,     1'b0, 5'd0, 32'h2A);
    chk_log("t2_w1", lb + 1, 1'b0, 5'd1, 32'd4);
    chk_log("t2_w2", lb + 2, 1'b0, 5'd2, 32'h10);
    for (int i = 3; i < 7; i++) chk_log("t2_rd", lb + i, 1'b1, 5'd2, 32'h0);
    chk("t2_rd_gap", log_cyc[lb + 4] - log_cyc[lb + 3], GAP + 1);
    chk("t2_ndone", n_done - nd, 32'd1);
    chk("t2_nerr", n_err - ne, 32'd0);

    // 3: zero-size job is rejected without bus traffic
    lb = n_log; nd = n_done; ne = n_err;
    run_job(1'b0, 12'h055, 16'd0, 1'b1, 32'h1234, acc);
    chk("t3_err_pulse", {30'd0, m_err, m_busy}, 32'd3);
    @(negedge clk);
    chk("t3_back_idle", {30'd0, m_err, m_ready}, 32'd1);
    chk("t3_err_cyc", err_cyc, acc + 1);
    repeat (3) @(negedge clk);
    chk("t3_nlog", n_log - lb, 32'd0);
    chk("t3_nerr", n_err - ne, 32'd1);
    chk("t3_ndone", n_done - nd, 32'd0);

    // 4: timeout instance (MAX_POLLS=2), channel never finishes
    sel = 1'b1;
    lb = n_log; nd = n_done; ne = n_err; rd_base = n_reads; busy_polls = 1000; busy_val = 32'h10;
    run_job(1'b0, 12'h080, 16'd32, 1'b0, 32'h0, acc);
    wait_evt(nd, ne);
    chk("t4_nlog", n_log - lb, 32'd6);
    chk_log("t4_w0", lb,     1'b0, 5'd4, 32'h80);
    chk_log("t4_w2", lb + 2, 1'b0, 5'd6, 32'h10);
    chk_log("t4_rd0", lb + 3, 1'b1, 5'd6, 32'h0);
    chk_log("t4_rd1", lb + 4, 1'b1, 5'd6, 32'h0);
    chk_log("t4_clr", lb + 5, 1'b0, 5'd6, 32'h40);
    chk("t4_err_cyc", err_cyc, log_cyc[lb + 5] + 1);
    chk("t4_nerr", n_err - ne, 32'd1);
    chk("t4_ndone", n_done - nd, 32'd0);
    sel = 1'b0; busy_polls = 0;

    // 5: slave stalls the SIZE write for five cycles
    lb = n_log; nd = n_done; ne = n_err; ns = n_stall; rd_base = n_reads;
    stall_addr = 5'd5; stall_data = 32'd20; stall_on = 1'b1;
    run_job(1'b0, 12'h044, 16'd20, 1'b0, 32'h0, acc);
    wait_evt(nd, ne);
    stall_on = 1'b0;
    chk("t5_nstall", n_stall - ns, 32'd5);
    chk("t5_nlog", n_log - lb, 32'd4);
    chk_log("t5_w0", lb,     1'b0, 5'd4, 32'h44);
    chk_log("t5_w1", lb + 1, 1'b0, 5'd5, 32'd20);
    chk_log("t5_w2", lb + 2, 1'b0, 5'd6, 32'h10);
    chk("t5_w1_cyc", log_cyc[lb + 1], acc + 7);
    chk("t5_w2_cyc", log_cyc[lb + 2], acc + 8);
    chk("t5_ndone", n_done - nd, 32'd1);

    // 6: reset while waiting between polls, then a fresh job
    lb = n_log; nd = n_done; ne = n_err; rd_base = n_reads;
    run_job(1'b1, 12'h010, 16'd8, 1'b0, 32'h0, acc);
    repeat (5) @(negedge clk);
    chk("t6_in_gap", {30'd0, m_busy, m_valid}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("t6_reset");
    repeat (15) @(negedge clk);
    chk("t6_nlog", n_log - lb, 32'd3);
    chk("t6_no_evt", (n_done - nd) + (n_err - ne), 32'd0);
    lb = n_log;
    run_job(1'b0, 12'h200, 16'd2, 1'b0, 32'h0, acc);
    wait_evt(nd, ne);
    chk("t6_nlog2", n_log - lb, 32'd4);
    chk_log("t6_w0", lb, 1'b0, 5'd4, 32'h200);
    chk("t6_ndone", n_done - nd, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
